// File: rtl/if_stage_if.sv
// Bundle of the IF stage's downstream handshake, branch input and
// instruction SRAM port. The IF stage takes the master side; ID and the
// SRAM together make up the slave side.
interface if_stage_if;
   logic        ds_allowin;
   logic [32:0] br_bus;
   logic        fs_to_ds_valid;
   logic [63:0] fs_to_ds_bus;
   logic        inst_sram_en;
   logic        inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   modport master (
      input  ds_allowin,
      input  br_bus,
      input  inst_sram_rdata,
      output fs_to_ds_valid,
      output fs_to_ds_bus,
      output inst_sram_en,
      output inst_sram_we,
      output inst_sram_addr,
      output inst_sram_wdata
   );

   modport slave (
      output ds_allowin,
      output br_bus,
      output inst_sram_rdata,
      input  fs_to_ds_valid,
      input  fs_to_ds_bus,
      input  inst_sram_en,
      input  inst_sram_we,
      input  inst_sram_addr,
      input  inst_sram_wdata
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, issues one request per cycle to a
// synchronous-read instruction SRAM, and hands {pc, inst} to ID through a
// valid/allowin handshake. Returned data is buffered across ID stalls.
// A taken branch always kills the instruction IF is holding. If IF is
// blocked when the branch arrives, the target is parked and fetched on the
// following cycle.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
   input logic        clk,
   input logic        reset,
   if_stage_if.master fs
);

   logic        br_taken;
   logic [31:0] br_target;
   logic        to_fs_valid;
   logic        fs_ready_go;
   logic        fs_allowin;
   logic        fetch;
   logic        hand_off;
   logic        capture;
   logic [31:0] nextpc;
   logic [31:0] fs_inst;

   logic        fs_valid;
   logic [31:0] fs_pc;
   logic        inst_buf_valid;
   logic [31:0] inst_buf;
   logic        br_pending;
   logic [31:0] pend_target;

   assign br_taken  = fs.br_bus[32];
   assign br_target = fs.br_bus[31:0];

   // Pre-IF address selection and the IF/ID handshake. A parked branch
   // target takes priority, then a branch arriving this cycle, then the
   // sequential PC (32-bit wrap).
   always_comb begin
      to_fs_valid = ~reset;
      fs_ready_go = 1'b1;
      fs_allowin  = ~fs_valid | (fs_ready_go & fs.ds_allowin);
      fetch       = to_fs_valid & fs_allowin;
      hand_off    = fs_valid & fs_ready_go & fs.ds_allowin;
      capture     = fs_valid & ~inst_buf_valid & ~fs_allowin & ~br_taken;
      nextpc      = fs_pc + 32'd4;
      if (br_pending) begin
         nextpc = pend_target;
      end else if (br_taken) begin
         nextpc = br_target;
      end
      fs_inst = inst_buf_valid ? inst_buf : fs.inst_sram_rdata;

      fs.inst_sram_en    = fetch;
      fs.inst_sram_we    = 1'b0;
      fs.inst_sram_addr  = nextpc;
      fs.inst_sram_wdata = 32'd0;
      fs.fs_to_ds_valid  = fs_valid & fs_ready_go & ~br_taken;
      fs.fs_to_ds_bus    = {fs_pc, fs_inst};
   end

   // Control state: IF occupancy, PC, buffer-occupied flag and the parked
   // branch flag. A blocked branch empties IF, which forces allowin high on
   // the next cycle so the parked target is fetched right away.
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid       <= 1'b0;
         fs_pc          <= RESET_PC;
         inst_buf_valid <= 1'b0;
         br_pending     <= 1'b0;
      end else begin
         if (fetch) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
         end else if (br_taken | hand_off) begin
            fs_valid <= 1'b0;
         end

         if (fetch | br_taken | hand_off) begin
            inst_buf_valid <= 1'b0;
         end else if (capture) begin
            inst_buf_valid <= 1'b1;
         end

         if (fetch) begin
            br_pending <= 1'b0;
         end
         if (br_taken & (~fs_allowin | br_pending)) begin
            br_pending <= 1'b1;
         end
      end
   end

   // Data holding registers: the SRAM word seen while ID stalls, and the
   // target of a branch that could not be fetched immediately.
   always_ff @(posedge clk) begin
      if (capture) begin
         inst_buf <= fs.inst_sram_rdata;
      end
      if (br_taken & (~fs_allowin | br_pending)) begin
         pend_target <= br_target;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. A small SRAM model answers each request
// on the next cycle and returns random garbage otherwise. A transaction-level
// model predicts what ID must see: it tracks which instruction IF holds and
// which target is parked, and it knows each instruction's contents directly
// from its address.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h1bfffffc;
   localparam logic [31:0] KEY      = 32'h13579bdf;

   logic clk;
   logic reset;

   if_stage_if fsif ();

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .fs    (fsif)
   );

   int checks = 0;
   int fails  = 0;

   bit          m_init  = 1'b0;
   bit          m_valid = 1'b0;
   bit          m_pend  = 1'b0;
   logic [31:0] m_pc    = 32'd0;
   logic [31:0] m_inst  = 32'd0;
   logic [31:0] m_tgt   = 32'd0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction SRAM: data is valid only in the cycle after a request.
   always @(posedge clk) begin
      if (fsif.inst_sram_en) begin
         fsif.inst_sram_rdata <= mem(fsif.inst_sram_addr);
      end else begin
         fsif.inst_sram_rdata <= $urandom;
      end
   end

   task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit a, input bit bt, input logic [31:0] tgt);
      @(negedge clk);
      reset           = r;
      fsif.ds_allowin = a;
      fsif.br_bus     = {bt, tgt};
      #1;
   endtask

   // Compares DUT outputs with the model for the current cycle, then
   // advances the model to what holds after the coming rising edge.
   task automatic checkOutput();
      bit          bt;
      logic [31:0] tgt;
      bit          exp_valid;
      bit          exp_en;
      logic [31:0] exp_addr;
      bt        = fsif.br_bus[32];
      tgt       = fsif.br_bus[31:0];
      exp_valid = m_valid && !bt;
      exp_en    = !reset && (!m_valid || fsif.ds_allowin);
      exp_addr  = m_pend ? m_tgt : (bt ? tgt : m_pc + 32'd4);
      if (m_init) begin
         compare("fs_to_ds_valid", 64'(fsif.fs_to_ds_valid), 64'(exp_valid));
         if (exp_valid) begin
            compare("fs_to_ds_bus", fsif.fs_to_ds_bus, {m_pc, m_inst});
         end
         compare("inst_sram_en", 64'(fsif.inst_sram_en), 64'(exp_en));
         compare("inst_sram_addr", 64'(fsif.inst_sram_addr), 64'(exp_addr));
         compare("inst_sram_we", 64'(fsif.inst_sram_we), 64'd0);
         compare("inst_sram_wdata", 64'(fsif.inst_sram_wdata), 64'd0);
      end
      if (reset) begin
         m_init  = 1'b1;
         m_valid = 1'b0;
         m_pend  = 1'b0;
         m_pc    = RESET_PC;
      end else if (exp_en) begin
         m_valid = 1'b1;
         m_pc    = exp_addr;
         m_inst  = mem(exp_addr);
         m_pend  = 1'b0;
      end else if (bt) begin
         m_valid = 1'b0;
         m_pend  = 1'b1;
         m_tgt   = tgt;
      end
   endtask

   task automatic cyc(input bit r, input bit a, input bit bt, input logic [31:0] tgt);
      applyStimulus(r, a, bt, tgt);
      checkOutput();
   endtask

   initial begin
      reset           = 1'b1;
      fsif.ds_allowin = 1'b0;
      fsif.br_bus     = 33'd0;

      // Reset state
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      compare("reset_en", 64'(fsif.inst_sram_en), 64'd0);
      compare("reset_valid", 64'(fsif.fs_to_ds_valid), 64'd0);
      compare("reset_addr", 64'(fsif.inst_sram_addr), 64'h1c000000);
      compare("reset_pc", 64'(fsif.fs_to_ds_bus[63:32]), 64'h1bfffffc);

      // First fetch and streaming
      cyc(0, 1, 0, 0);
      compare("first_en", 64'(fsif.inst_sram_en), 64'd1);
      compare("first_addr", 64'(fsif.inst_sram_addr), 64'h1c000000);
      cyc(0, 1, 0, 0);
      compare("first_valid", 64'(fsif.fs_to_ds_valid), 64'd1);
      compare("first_bus", fsif.fs_to_ds_bus, 64'h1c000000_0f579bdf);
      compare("second_addr", 64'(fsif.inst_sram_addr), 64'h1c000004);

      // Stall while holding 1c000004; SRAM data turns to garbage
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0);
         compare("stall_en", 64'(fsif.inst_sram_en), 64'd0);
         compare("stall_bus", fsif.fs_to_ds_bus, {32'h1c000004, 32'h1c000004 ^ KEY});
      end
      cyc(0, 1, 0, 0);
      compare("release_addr", 64'(fsif.inst_sram_addr), 64'h1c000008);

      // Branch while flowing
      cyc(0, 1, 1, 32'h1c000100);
      compare("br_flow_kill", 64'(fsif.fs_to_ds_valid), 64'd0);
      compare("br_flow_addr", 64'(fsif.inst_sram_addr), 64'h1c000100);
      cyc(0, 1, 0, 0);
      compare("br_flow_pc", 64'(fsif.fs_to_ds_bus[63:32]), 64'h1c000100);

      // Branch while blocked
      cyc(0, 0, 1, 32'h1c000200);
      compare("br_block_kill", 64'(fsif.fs_to_ds_valid), 64'd0);
      compare("br_block_en", 64'(fsif.inst_sram_en), 64'd0);
      cyc(0, 0, 0, 0);
      compare("br_pend_en", 64'(fsif.inst_sram_en), 64'd1);
      compare("br_pend_addr", 64'(fsif.inst_sram_addr), 64'h1c000200);
      cyc(0, 0, 0, 0);
      compare("br_pend_pc", 64'(fsif.fs_to_ds_bus[63:32]), 64'h1c000200);
      cyc(0, 1, 0, 0);

      // Wrap-around
      cyc(0, 1, 1, 32'hfffffffc);
      compare("wrap_tgt", 64'(fsif.inst_sram_addr), 64'hfffffffc);
      cyc(0, 1, 0, 0);
      compare("wrap_addr", 64'(fsif.inst_sram_addr), 64'h00000000);

      // Reset while a branch is parked
      cyc(0, 0, 1, 32'h1c000300);
      cyc(1, 1, 0, 0);
      compare("rst_pend_en", 64'(fsif.inst_sram_en), 64'd0);
      cyc(0, 1, 0, 0);
      compare("rst_pend_addr", 64'(fsif.inst_sram_addr), 64'h1c000000);
      cyc(0, 1, 0, 0);
      compare("rst_pend_pc", 64'(fsif.fs_to_ds_bus[63:32]), 64'h1c000000);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bit          r;
         bit          a;
         bit          bt;
         logic [31:0] tgt;
         r  = ($urandom_range(0, 63) == 0);
         a  = ($urandom_range(0, 9) < 7);
         bt = !r && !m_pend && ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0:       tgt = 32'hfffffffc;
            1:       tgt = $urandom;
            default: tgt = 32'h1c000000 + (32'($urandom_range(0, 255)) << 2);
         endcase
         cyc(r, a, bt, tgt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
